// File: rtl/mux8_rr_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux8_rr_scheduler : round-robin time-slot owner of an 8:1 mux select.
// Optional macro MUX8_SCHED_LOCK_EN adds a lock input.  Rev 1.0
// ---------------------------------------------------------------------------
module mux8_rr_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
`ifdef MUX8_SCHED_LOCK_EN
  input  logic       lock,
`endif
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy
);

  localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  logic [2:0]        ptr;
  logic [HOLD_W-1:0] cnt;

  logic [2:0] search_start;
  logic [2:0] winner;
  logic       found;
  logic       owner_req;
  logic       cnt_zero;
  logic       release_now;
  logic       frozen;

  // While granted, the search already starts at sel+1 so a release can hand
  // the mux straight to the next winner without an idle cycle.
  always_comb begin
    logic [2:0] idx;
    idx          = 3'd0;
    search_start = (state == GRANT) ? sel + 3'd1 : ptr;
    found        = 1'b0;
    winner       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = search_start + 3'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign owner_req = req[sel];
  assign cnt_zero  = (cnt == '0);

`ifdef MUX8_SCHED_LOCK_EN
  // Lock only stretches a live slot; a dropped request still releases.
  assign frozen      = lock && owner_req;
  assign release_now = !owner_req || (cnt_zero && !lock);
`else
  assign frozen      = 1'b0;
  assign release_now = !owner_req || cnt_zero;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      cnt   <= '0;
      sel   <= 3'd0;
      gnt   <= 8'd0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            sel   <= winner;
            gnt   <= 8'd1 << winner;
            busy  <= 1'b1;
            cnt   <= RELOAD;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr <= sel + 3'd1;
            if (found) begin
              sel <= winner;
              gnt <= 8'd1 << winner;
              cnt <= RELOAD;
            end else begin
              state <= IDLE;
              gnt   <= 8'd0;
              busy  <= 1'b0;
            end
          end else if (!frozen) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 8'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
